// File: rtl/key_filter.sv
// rtl/key_filter.sv - push-button debouncer with press/release strobes
module key_filter #(
    parameter int CNT_MAX = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_flag,
    output logic key_release_flag
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        DOWN,
        REL_FILT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          key_meta;
    logic          key_sync;

    // Two-stage synchronizer; idles high so reset reads as "released".
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    // Debounce FSM: a level must hold for CNT_MAX filter cycles before it is accepted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            key_state        <= 1'b1;
            key_flag         <= 1'b0;
            key_release_flag <= 1'b0;
        end else begin
            key_flag         <= 1'b0;
            key_release_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_sync) begin
                        state <= PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (key_sync) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= DOWN;
                        key_flag  <= 1'b1;
                        key_state <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DOWN: begin
                    if (key_sync) begin
                        state <= REL_FILT;
                        cnt   <= '0;
                    end
                end
                REL_FILT: begin
                    if (!key_sync) begin
                        state <= DOWN;
                    end else if (cnt == CNT_LAST) begin
                        state            <= IDLE;
                        key_release_flag <= 1'b1;
                        key_state        <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_filter.sv
// tb/tb_key_filter.sv - scoreboard bench for key_filter
module tb_key_filter;

    localparam int CNT_MAX = 4;

    logic sys_clk;
    logic sys_rst_n;
    logic key_in;
    logic key_state;
    logic key_flag;
    logic key_release_flag;

    key_filter #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .key_in           (key_in),
        .key_state        (key_state),
        .key_flag         (key_flag),
        .key_release_flag (key_release_flag)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    typedef struct {
        bit rel;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;

    // Reference: accepted level flips once CNT_MAX+1 consecutive delayed samples disagree with it.
    bit  ref_level;
    int  ref_run;
    bit  ref_d1, ref_d2;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, stepping once per clock edge on the key sample history.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        bit s;
        if (!sys_rst_n) begin
            ref_level = 1'b1;
            ref_run   = 0;
            ref_d1    = 1'b1;
            ref_d2    = 1'b1;
            exp_q.delete();
        end else begin
            cyc++;
            s      = ref_d2;
            ref_d2 = ref_d1;
            ref_d1 = key_in;
            if (s == ref_level) begin
                ref_run = 0;
            end else begin
                ref_run++;
                if (ref_run == CNT_MAX + 1) begin
                    ref_level = s;
                    ref_run   = 0;
                    exp_q.push_back('{rel: s, cyc: cyc});
                end
            end
        end
    end

    // Monitor: compares level every cycle and pops an expected event for each strobe.
    always @(negedge sys_clk) begin
        ev_t e;
        check("key_state", int'(key_state), int'(ref_level));
        if (key_flag && key_release_flag)
            check("both_flags", 1, 0);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_flag_cycle", -1, e.cyc);
        end
        if (key_flag || key_release_flag) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flag", int'(key_release_flag), -1);
            end else begin
                e = exp_q.pop_front();
                check("flag_kind", int'(key_release_flag), int'(e.rel));
                check("flag_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Drive low at a negedge and confirm the strobe lands exactly on the CNT_MAX+3 edge.
    task automatic timed_edge(input bit lvl, input string name);
        @(negedge sys_clk);
        key_in = lvl;
        repeat (CNT_MAX + 2) @(posedge sys_clk);
        #1;
        check({name, "_early"}, int'(lvl ? key_release_flag : key_flag), 0);
        @(posedge sys_clk);
        #1;
        check({name, "_flag"}, int'(lvl ? key_release_flag : key_flag), 1);
        check({name, "_state"}, int'(key_state), int'(lvl));
    endtask

    initial begin
        bit hold_val;
        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        cycles(3);
        check("rst_state", int'(key_state), 1);
        check("rst_flag", int'(key_flag), 0);
        check("rst_rel_flag", int'(key_release_flag), 0);
        sys_rst_n = 1'b1;
        cycles(3);

        // Clean press held, then clean release.
        timed_edge(1'b0, "press");
        cycles(14);
        timed_edge(1'b1, "release");
        cycles(10);

        // Press bounce: low 3, high 2, low steady.
        key_in = 1'b0; cycles(3);
        key_in = 1'b1; cycles(2);
        key_in = 1'b0; cycles(20);
        check("bounce_press_state", int'(key_state), 0);

        // Release bounce: high 2 then back low; must remain pressed.
        key_in = 1'b1; cycles(2);
        key_in = 1'b0; cycles(15);
        check("bounce_rel_state", int'(key_state), 0);

        // Reset while DOWN: key_state must return high without waiting for a clock.
        @(posedge sys_clk);
        #5 sys_rst_n = 1'b0;
        #1;
        check("rst_down_state", int'(key_state), 1);
        cycles(2);
        sys_rst_n = 1'b1;
        key_in    = 1'b1;
        cycles(10);

        // Reset mid press filter, key still held afterwards.
        @(negedge sys_clk);
        key_in = 1'b0;
        repeat (5) @(posedge sys_clk);
        #5 sys_rst_n = 1'b0;
        #1;
        check("rst_mid_state", int'(key_state), 1);
        check("rst_mid_flag", int'(key_flag), 0);
        check("rst_mid_rel", int'(key_release_flag), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (CNT_MAX + 2) @(posedge sys_clk);
        #1;
        check("post_rst_early", int'(key_flag), 0);
        @(posedge sys_clk);
        #1;
        check("post_rst_flag", int'(key_flag), 1);
        cycles(5);

        // Random toggling with periodic long holds alternating level.
        hold_val = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            if (i % 100 == 0)
                hold_val = ~hold_val;
            if (i % 100 < 15)
                key_in = hold_val;
            else
                key_in = 1'($urandom_range(0, 1));
        end

        @(negedge sys_clk);
        key_in = 1'b1;
        cycles(20);
        check("queue_empty", exp_q.size(), 0);
        check("final_state", int'(key_state), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
